// File: rtl/snn_frame_ctrl.sv
// snn_frame_ctrl
// Sequences one SNN inference per UART frame:
//   collect NUM_BYTES image bytes -> pulse core_start -> wait core_done
//   -> send the classified digit through uart_tx -> back to collecting.
// This block owns the frame byte counter and the partial-frame idle timeout.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   rx_rdy/rx_data  one-cycle strobe plus the received byte
//   ram_we/ram_waddr/ram_wdata
//                   registered input-RAM write port (one cycle after rx_rdy)
//   core_start      one-cycle pulse that starts inference on the RAM contents
//   core_done/core_digit
//                   one-cycle pulse from the core with the classified digit
//   tx_start/tx_data
//                   one-cycle pulse to uart_tx; tx_data is held until the next send
//   tx_rdy          uart_tx idle (high means a new byte may be started)
//   busy            high in every state except RECV
//   frame_err       sticky: byte dropped while busy, or partial frame timed out
//   state_dbg       current FSM state encoding (RECV=0 .. WAIT_TX=4)
//
// Handshakes: rx_rdy, core_start, core_done and tx_start are single-cycle
// strobes with no back-pressure. The only flow control is tx_rdy: a byte is
// launched only while tx_rdy is high, and the transmitter is considered
// finished once tx_rdy has been seen low and then high again.
module snn_frame_ctrl #(
    parameter int NUM_BYTES    = 98,
    parameter int ADDR_W       = 7,
    parameter int TIMEOUT_CYC  = 100000,
    parameter bit RESULT_ASCII = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              frame_err,
    output logic [2:0]        state_dbg
);

    localparam int                TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_RECV      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_CORE = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_TX   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              core_start_q, core_start_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [3:0]        digit_q, digit_d;
    logic              frame_err_q, frame_err_d;
    logic              seen_low_q, seen_low_d;

    logic              timeout_hit;
    logic [ADDR_W-1:0] wr_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RECV;
            count_q      <= '0;
            tcnt_q       <= '0;
            ram_we_q     <= 1'b0;
            ram_waddr_q  <= '0;
            ram_wdata_q  <= '0;
            core_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            digit_q      <= '0;
            frame_err_q  <= 1'b0;
            seen_low_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tcnt_q       <= tcnt_d;
            ram_we_q     <= ram_we_d;
            ram_waddr_q  <= ram_waddr_d;
            ram_wdata_q  <= ram_wdata_d;
            core_start_q <= core_start_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            digit_q      <= digit_d;
            frame_err_q  <= frame_err_d;
            seen_low_q   <= seen_low_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        tcnt_d       = tcnt_q;
        ram_we_d     = 1'b0;
        ram_waddr_d  = ram_waddr_q;
        ram_wdata_d  = ram_wdata_q;
        core_start_d = 1'b0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        digit_d      = digit_q;
        frame_err_d  = frame_err_q;
        seen_low_d   = seen_low_q;
        timeout_hit  = 1'b0;
        wr_idx       = count_q;

        // Any byte arriving outside RECV is lost; remember that.
        if (rx_rdy && (state_q != S_RECV)) begin
            frame_err_d = 1'b1;
        end

        case (state_q)
            S_RECV: begin
                // tcnt holds the number of idle cycles since the last byte of a
                // partial frame; the cycle in which it equals TIMEOUT_CYC is the
                // expiry cycle. An empty frame (count 0) keeps tcnt at 0.
                timeout_hit = (count_q != '0) && (tcnt_q == TO_LIMIT);
                if (timeout_hit) begin
                    frame_err_d = 1'b1;
                    count_d     = '0;
                    tcnt_d      = '0;
                end else if ((count_q != '0) && !rx_rdy) begin
                    tcnt_d = tcnt_q + 1'b1;
                end

                if (rx_rdy) begin
                    // A byte landing on the expiry cycle starts a fresh frame.
                    wr_idx      = timeout_hit ? '0 : count_q;
                    ram_we_d    = 1'b1;
                    ram_waddr_d = wr_idx;
                    ram_wdata_d = rx_data;
                    tcnt_d      = '0;
                    if (wr_idx == LAST_IDX) begin
                        count_d = '0;
                        state_d = S_START;
                    end else begin
                        count_d = wr_idx + 1'b1;
                    end
                end
            end

            S_START: begin
                // Entered right after the last byte was sampled, so the pulse
                // appears the cycle after the last RAM write.
                core_start_d = 1'b1;
                state_d      = S_WAIT_CORE;
            end

            S_WAIT_CORE: begin
                if (core_done) begin
                    digit_d = core_digit;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_rdy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = RESULT_ASCII ? (8'h30 + {4'h0, digit_q})
                                              : {4'h0, digit_q};
                    seen_low_d = 1'b0;
                    state_d    = S_WAIT_TX;
                end
            end

            S_WAIT_TX: begin
                // tx_start_q is high in the first WAIT_TX cycle; uart_tx has
                // not reacted yet, so tx_rdy is meaningless there.
                if (!tx_start_q) begin
                    if (!seen_low_q) begin
                        if (!tx_rdy) begin
                            seen_low_d = 1'b1;
                        end
                    end else if (tx_rdy) begin
                        seen_low_d = 1'b0;
                        count_d    = '0;
                        state_d    = S_RECV;
                    end
                end
            end

            default: begin
                state_d = S_RECV;
            end
        endcase
    end

    assign ram_we     = ram_we_q;
    assign ram_waddr  = ram_waddr_q;
    assign ram_wdata  = ram_wdata_q;
    assign core_start = core_start_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = (state_q != S_RECV);
    assign frame_err  = frame_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// tb_snn_frame_ctrl
// Bench for snn_frame_ctrl. Two instances share every input: one sends ASCII
// results, the other raw digits. RAM writes and transmitted bytes are compared
// against expected queues filled by the driver tasks; a small uart_tx model
// drives tx_rdy.
module tb_snn_frame_ctrl;

  localparam int NB  = 98;
  localparam int AW  = 7;
  localparam int TOC = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          core_done;
  logic [3:0]    core_digit;
  logic          tx_rdy;

  logic          ram_we, ram_we_r;
  logic [AW-1:0] ram_waddr, ram_waddr_r;
  logic [7:0]    ram_wdata, ram_wdata_r;
  logic          core_start, core_start_r;
  logic          tx_start, tx_start_r;
  logic [7:0]    tx_data, tx_data_r;
  logic          busy, busy_r;
  logic          frame_err, frame_err_r;
  logic [2:0]    state_dbg, state_dbg_r;

  snn_frame_ctrl #(
    .NUM_BYTES(NB), .ADDR_W(AW), .TIMEOUT_CYC(TOC), .RESULT_ASCII(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .busy(busy), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  snn_frame_ctrl #(
    .NUM_BYTES(NB), .ADDR_W(AW), .TIMEOUT_CYC(TOC), .RESULT_ASCII(1'b0)
  ) dut_raw (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_we(ram_we_r), .ram_waddr(ram_waddr_r), .ram_wdata(ram_wdata_r),
    .core_start(core_start_r), .core_done(core_done), .core_digit(core_digit),
    .tx_start(tx_start_r), .tx_data(tx_data_r), .tx_rdy(tx_rdy),
    .busy(busy_r), .frame_err(frame_err_r), .state_dbg(state_dbg_r)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [14:0] exp_wq[$];   // {addr, data} of expected RAM writes
  logic [15:0] exp_tq[$];   // {ascii byte, raw byte} of expected transmissions
  int          n_total = 0;
  int          n_bad   = 0;
  int          n_start = 0;
  int          n_tx    = 0;
  logic        last_wr = 1'b0;
  logic [14:0] ew;
  logic [15:0] et;
  logic [7:0]  last_ascii = 8'h00;
  logic        tx_hold = 1'b0;
  int          uart_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- uart_tx model ----------------
  initial begin
    tx_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_start) uart_cnt = 8;
      else if (uart_cnt > 0) uart_cnt--;
      tx_rdy = !tx_hold && (uart_cnt == 0);
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        if (exp_wq.size() == 0) begin
          check("ram_we_unexpected", 32'(ram_we), 32'd0);
        end else begin
          ew = exp_wq.pop_front();
          check("ram_addr", 32'(ram_waddr), 32'(ew[14:8]));
          check("ram_data", 32'(ram_wdata), 32'(ew[7:0]));
        end
      end
      if (core_start) begin
        n_start++;
        check("start_after_last_wr", 32'(last_wr), 32'd1);
      end
      last_wr = ram_we && (ram_waddr == AW'(NB - 1));
      if (tx_start) begin
        n_tx++;
        check("tx_start_raw_dut", 32'(tx_start_r), 32'd1);
        if (exp_tq.size() == 0) begin
          check("tx_start_unexpected", 32'(tx_start), 32'd0);
        end else begin
          et = exp_tq.pop_front();
          check("tx_ascii", 32'(tx_data), 32'(et[15:8]));
          check("tx_raw", 32'(tx_data_r), 32'(et[7:0]));
        end
      end
    end else begin
      last_wr = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    exp_wq.delete();
    exp_tq.delete();
    check("rst_outputs",
          32'({ram_we, ram_waddr, ram_wdata, core_start, tx_start, tx_data,
               busy, frame_err, state_dbg}), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit accept, input logic [AW-1:0] a);
    rx_rdy  = 1'b1;
    rx_data = d;
    if (accept) exp_wq.push_back({a, d});
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < NB; i++) send_byte(8'(base + 8'(i)), 1'b1, AW'(i));
  endtask

  task automatic wait_start(input int s0);
    int k = 0;
    while (n_start == s0 && k < 500) begin
      tick();
      k++;
    end
    check("core_start_seen", 32'(n_start - s0), 32'd1);
  endtask

  task automatic core_reply(input logic [3:0] dg, input bit expect_tx);
    logic [7:0] a;
    a = 8'h30 + {4'h0, dg};
    core_digit = dg;
    core_done  = 1'b1;
    if (expect_tx) begin
      exp_tq.push_back({a, 4'h0, dg});
      last_ascii = a;
    end
    tick();
    core_done = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin
      tick();
      k++;
    end
    check("back_to_recv", 32'(busy), 32'd0);
    check("tx_data_held", 32'(tx_data), 32'(last_ascii));
    check("tx_queue_drained", 32'(exp_tq.size()), 32'd0);
  endtask

  task automatic run_core(input logic [3:0] dg, input int s0);
    wait_start(s0);
    tick(3);
    core_reply(dg, 1'b1);
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  int s0;
  int t0;

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; core_done = 1'b0; core_digit = '0;
    do_reset();

    // Full frame, ASCII digit 7 back
    s0 = n_start;
    send_frame(8'h00);
    run_core(4'd7, s0);
    check("one_start_frame1", 32'(n_start - s0), 32'd1);
    check("no_err_frame1", 32'(frame_err), 32'd0);

    // core_done in RECV is ignored
    t0 = n_tx;
    core_reply(4'd3, 1'b0);
    tick(20);
    check("core_done_ignored", 32'(n_tx - t0), 32'd0);
    check("still_recv", 32'(state_dbg), 32'd0);

    // Digit above 9 goes out unclamped
    s0 = n_start;
    send_frame(8'h40);
    run_core(4'd12, s0);

    // Empty frame never times out
    tick(150);
    check("no_timeout_empty", 32'(frame_err), 32'd0);

    // Partial frame of 50 bytes, then idle past the timeout
    for (int i = 0; i < 50; i++) send_byte(8'(8'h80 + 8'(i)), 1'b1, AW'(i));
    tick(TOC + 6);
    check("timeout_err", 32'(frame_err), 32'd1);
    check("timeout_not_busy", 32'(busy), 32'd0);
    s0 = n_start;
    send_frame(8'h10);
    run_core(4'd2, s0);
    check("one_start_after_to", 32'(n_start - s0), 32'd1);

    // Timeout boundary: one idle cycle short, then exactly on expiry
    do_reset();
    s0 = n_start;
    send_byte(8'h5A, 1'b1, AW'(0));
    tick(TOC - 1);
    send_byte(8'h5B, 1'b1, AW'(1));
    check("short_idle_no_err", 32'(frame_err), 32'd0);
    tick(TOC);
    send_byte(8'h5C, 1'b1, AW'(0));
    check("expiry_same_cycle_err", 32'(frame_err), 32'd1);
    for (int i = 1; i < NB; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, AW'(i));
    run_core(4'd9, s0);

    // Byte during WAIT_CORE is dropped
    do_reset();
    s0 = n_start;
    send_frame(8'h20);
    wait_start(s0);
    send_byte(8'hEE, 1'b0, AW'(0));
    check("drop_err", 32'(frame_err), 32'd1);
    check("drop_busy", 32'(busy), 32'd1);
    tick(2);
    core_reply(4'd5, 1'b1);
    wait_idle();
    s0 = n_start;
    send_frame(8'h30);
    run_core(4'd0, s0);

    // tx_rdy held low in SEND
    do_reset();
    s0 = n_start;
    send_frame(8'h50);
    wait_start(s0);
    tx_hold = 1'b1;
    tick(2);
    t0 = n_tx;
    core_reply(4'd4, 1'b0);
    tick(200);
    check("no_tx_while_busy_uart", 32'(n_tx - t0), 32'd0);
    check("state_send", 32'(state_dbg), 32'd3);
    exp_tq.push_back({8'h34, 8'h04});
    last_ascii = 8'h34;
    tx_hold = 1'b0;
    wait_idle();
    check("one_tx_after_release", 32'(n_tx - t0), 32'd1);

    // Reset mid-frame, in WAIT_CORE, and while START is pending
    do_reset();
    for (int i = 0; i < 40; i++) send_byte(8'(i), 1'b1, AW'(i));
    do_reset();
    s0 = n_start;
    send_frame(8'h60);
    wait_start(s0);
    do_reset();
    t0 = n_tx;
    core_reply(4'd8, 1'b0);
    tick(20);
    check("no_tx_after_rst", 32'(n_tx - t0), 32'd0);
    check("idle_after_rst", 32'(busy), 32'd0);
    s0 = n_start;
    send_frame(8'h70);
    do_reset();
    tick(5);
    check("no_start_after_rst", 32'(n_start - s0), 32'd0);
    s0 = n_start;
    send_frame(8'h00);
    run_core(4'd1, s0);
    check("frame_after_rst_clean", 32'(frame_err), 32'd0);

    tick(5);
    check("wr_queue_drained", 32'(exp_wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
